tcam_lookup: RTL and testbench

Search-side controller for the SRL-based fractional TCAM. It takes an NFRAG×5-bit search key and drives each fragment's SRL32 read address. It then ANDs the per-rule match bits from all fragments and priority-encodes the surviving rule vector into a result stream. It also arbitrates SRL address ownership with the update logic, so a rule write never corrupts an in-flight search.

---
 rtl/tcam_lookup_pkg.sv | 40 ++++
 rtl/tcam_lookup_prio_enc.sv | 26 ++
 rtl/tcam_lookup.sv | 180 ++++++++++++++++++
 tb/tb_tcam_lookup.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_lookup_pkg.sv
// ---------------------------------------------------------------------------
// tcam_lookup_pkg
// Shared definitions for the SRL-based fractional TCAM:
//   FRAG_W     - key bits per fragment (one SRL32 bank address)
//   SRL_DEPTH  - entries per SRL bank
//   tcam_state_t - search/update arbitration states
//   tcam_clog2 / tcam_idx_w - width helpers shared with the update logic
// ---------------------------------------------------------------------------
package tcam_lookup_pkg;

   localparam int FRAG_W    = 5;
   localparam int SRL_DEPTH = 32;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      DRAIN  = 2'd1,
      GRANT  = 2'd2
   } tcam_state_t;

   // Ceiling log2 for elaboration-time width calculations.
   function automatic int tcam_clog2(input int value);
      int res;
      int rem;
      res = 32'sd0;
      rem = value - 32'sd1;
      while (rem > 32'sd0) begin
         res = res + 32'sd1;
         rem = rem >>> 1;
      end
      return res;
   endfunction

   // Index width for an n-entry vector, never narrower than one bit.
   function automatic int tcam_idx_w(input int n);
      int w;
      w = tcam_clog2(n);
      return (w < 32'sd1) ? 32'sd1 : w;
   endfunction

endpackage

// File: rtl/tcam_lookup_prio_enc.sv
// ---------------------------------------------------------------------------
// tcam_lookup_prio_enc
// Combinational lowest-set-bit priority encoder.
//   vec - input request vector (N bits)
//   idx - index of the lowest set bit, 0 when vec is all-zero
//   any - at least one bit of vec is set
// ---------------------------------------------------------------------------
module tcam_lookup_prio_enc #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan from the top down so the lowest set bit is written last and wins.
   always_comb begin
      idx = '0;
      any = |vec;
      for (int i = N - 1; i >= 0; i--) begin
         idx = vec[i] ? IW'(i) : idx;
      end
   end

endmodule

// File: rtl/tcam_lookup.sv
// ---------------------------------------------------------------------------
// tcam_lookup
// Search-side controller of the SRL-based fractional TCAM. A key is split
// into 5-bit fragments that address the SRL banks; the per-rule match bits of
// all banks are ANDed and the surviving vector is priority encoded. The block
// also hands the SRL address path to the update logic once no search depends
// on the SRL contents.
// Ports:
//   wclk, rst          - clock, asynchronous active-high reset
//   s_key/s_valid/s_ready - search key stream (valid/ready)
//   srl_addr           - registered read address, fragment f at [5f+4:5f]
//   srl_q              - combinational bank outputs, bank f at [NRULE*f +: NRULE]
//   upd_req/upd_gnt    - update ownership request / registered grant
//   m_valid/m_ready    - result stream handshake
//   m_match/m_index/m_vec - any-match, lowest matching rule, AND-ed vector
// ---------------------------------------------------------------------------
module tcam_lookup
   import tcam_lookup_pkg::*;
#(
   parameter int NFRAG = 4,
   parameter int NRULE = 8
) (
   input  logic                            wclk,
   input  logic                            rst,
   input  logic [FRAG_W*NFRAG-1:0]         s_key,
   input  logic                            s_valid,
   output logic                            s_ready,
   output logic [FRAG_W*NFRAG-1:0]         srl_addr,
   input  logic [NFRAG*NRULE-1:0]          srl_q,
   input  logic                            upd_req,
   output logic                            upd_gnt,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic                            m_match,
   output logic [tcam_idx_w(NRULE)-1:0]    m_index,
   output logic [NRULE-1:0]                m_vec
);

   localparam int IW = tcam_idx_w(NRULE);

   tcam_state_t      state_r;
   tcam_state_t      state_nxt_s;
   logic             ready_en_r;
   logic             v1_r;
   logic             v2_r;
   logic [NRULE-1:0] mvec_r;
   logic [NRULE-1:0] and_vec_s;
   logic [IW-1:0]    enc_idx_s;
   logic             enc_any_s;
   logic             s3_adv_s;
   logic             s2_adv_s;
   logic             s1_adv_s;
   logic             s_ready_s;
   logic             accept_s;
   logic             gnt_nxt_s;

   // Per-stage advance: a stage may load when it is empty or its content moves on.
   always_comb begin
      s3_adv_s = !m_valid || m_ready;
      s2_adv_s = !v2_r || s3_adv_s;
      s1_adv_s = !v1_r || s2_adv_s;
   end

   // Next-state and key-acceptance logic of the search/update arbiter.
   always_comb begin
      state_nxt_s = state_r;
      s_ready_s   = 1'b0;
      case (state_r)
         SEARCH: begin
            s_ready_s = ready_en_r && s1_adv_s && !upd_req;
            if (upd_req) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = SEARCH;
            end
         end
         DRAIN: begin
            // S3 may still hold a result; it no longer depends on the SRLs.
            if (!upd_req) begin
               state_nxt_s = SEARCH;
            end else if (!v1_r && !v2_r) begin
               state_nxt_s = GRANT;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         GRANT: begin
            if (!upd_req) begin
               state_nxt_s = SEARCH;
            end else begin
               state_nxt_s = GRANT;
            end
         end
         default: begin
            state_nxt_s = SEARCH;
         end
      endcase
      gnt_nxt_s = (state_nxt_s == GRANT);
   end

   assign s_ready  = s_ready_s;
   assign accept_s = s_valid && s_ready_s;

   // Arbiter state, registered grant and the post-reset ready enable.
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         state_r    <= SEARCH;
         upd_gnt    <= 1'b0;
         ready_en_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         upd_gnt    <= gnt_nxt_s;
         ready_en_r <= 1'b1;
      end
   end

   // S1: capture the accepted key as the SRL read address.
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         v1_r     <= 1'b0;
         srl_addr <= '0;
      end else begin
         if (s1_adv_s) begin
            v1_r <= accept_s;
         end
         // The address holds otherwise so a stalled S1 keeps srl_q stable.
         if (accept_s) begin
            srl_addr <= s_key;
         end
      end
   end

   // AND the per-rule match bits of every bank.
   always_comb begin
      and_vec_s = '1;
      for (int f = 0; f < NFRAG; f++) begin
         and_vec_s = and_vec_s & srl_q[f*NRULE +: NRULE];
      end
   end

   // S2: register the combined match vector.
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         v2_r   <= 1'b0;
         mvec_r <= '0;
      end else if (s2_adv_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            mvec_r <= and_vec_s;
         end
      end
   end

   tcam_lookup_prio_enc #(
      .N  (NRULE),
      .IW (IW)
   ) u_prio_enc (
      .vec (mvec_r),
      .idx (enc_idx_s),
      .any (enc_any_s)
   );

   // S3: output register, holds while the consumer back-pressures.
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_match <= 1'b0;
         m_index <= '0;
         m_vec   <= '0;
      end else if (s3_adv_s) begin
         m_valid <= v2_r;
         if (v2_r) begin
            m_match <= enc_any_s;
            m_index <= enc_idx_s;
            m_vec   <= mvec_r;
         end
      end
   end

endmodule

// File: tb/tb_tcam_lookup.sv
// ---------------------------------------------------------------------------
// tb_tcam_lookup
// Randomised scoreboard bench for tcam_lookup (NFRAG=4, NRULE=8). Rules are
// kept as whole-key value/mask pairs; the SRL banks are emulated per fragment
// and the expected result of each accepted key is computed from the full-key
// ternary compare.
// ---------------------------------------------------------------------------
module tb_tcam_lookup;

   logic        wclk = 1'b0;
   logic        rst  = 1'b1;
   logic [19:0] s_key = 20'h0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [19:0] srl_addr;
   logic [31:0] srl_q;
   logic        upd_req = 1'b0;
   logic        upd_gnt;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        m_match;
   logic [2:0]  m_index;
   logic [7:0]  m_vec;

   // Rule table: rule r matches key k when en[r] and (k & msk) == (val & msk).
   logic [19:0] val [8];
   logic [19:0] msk [8];
   logic [7:0]  en = 8'h00;

   typedef struct {
      logic [7:0] vec;
      int         acc;
      bit         lat;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   n_sent   = 0;
   int   n_issued = 0;
   bit   lat_mode = 1'b1;
   bit   rnd_done = 1'b0;
   logic       hold_pend = 1'b0;
   logic [7:0] hold_vec  = 8'h00;

   tcam_lookup #(.NFRAG(4), .NRULE(8)) dut (
      .wclk     (wclk),
      .rst      (rst),
      .s_key    (s_key),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .srl_addr (srl_addr),
      .srl_q    (srl_q),
      .upd_req  (upd_req),
      .upd_gnt  (upd_gnt),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_match  (m_match),
      .m_index  (m_index),
      .m_vec    (m_vec)
   );

   always #5 wclk = ~wclk;

   always @(posedge wclk) cyc <= cyc + 1;

   // SRL bank emulation: bank f, rule r answers for its own 5-bit fragment.
   always_comb begin
      srl_q = 32'h0;
      for (int f = 0; f < 4; f++) begin
         for (int r = 0; r < 8; r++) begin
            srl_q[f*8+r] = en[r] &&
               (((srl_addr[f*5 +: 5] ^ val[r][f*5 +: 5]) & msk[r][f*5 +: 5]) == 5'd0);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model_vec(input logic [19:0] key);
      logic [7:0] v;
      for (int r = 0; r < 8; r++) begin
         v[r] = en[r] && ((key & msk[r]) == (val[r] & msk[r]));
      end
      return v;
   endfunction

   function automatic int low_idx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [19:0] rand_key();
      int          r;
      logic [19:0] k;
      r = $urandom_range(0, 7);
      k = 20'($urandom);
      if ($urandom_range(0, 2) != 0 && en[r]) k = (val[r] & msk[r]) | (k & ~msk[r]);
      return k;
   endfunction

   // Push the expected result of every key the DUT will accept at the next edge.
   always @(negedge wclk) begin
      exp_t e;
      if (!rst && s_valid && s_ready) begin
         e.vec = model_vec(s_key);
         e.acc = cyc + 1;
         e.lat = lat_mode;
         sbq.push_back(e);
         n_sent <= n_sent + 1;
      end
   end

   // Output monitor: hold check under back-pressure and scoreboard compare.
   always @(negedge wclk) begin
      exp_t e;
      if (!rst) begin
         if (hold_pend) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_vec", 32'(m_vec), 32'(hold_vec));
         end
         if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
               chk("extra_result", 32'(sbq.size()), 32'd1);
            end else begin
               e = sbq.pop_front();
               chk("m_vec", 32'(m_vec), 32'(e.vec));
               chk("m_match", 32'(m_match), 32'(e.vec != 8'h00));
               chk("m_index", 32'(m_index), 32'(low_idx(e.vec)));
               if (e.lat) chk("latency", cyc, e.acc + 2);
            end
         end
         hold_pend <= m_valid && !m_ready;
         hold_vec  <= m_vec;
      end else begin
         hold_pend <= 1'b0;
      end
   end

   // Offer a key at posedge+1 and wait (bounded) until it is accepted.
   task automatic send(input logic [19:0] key);
      int t;
      s_key   = key;
      s_valid = 1'b1;
      t = 0;
      @(negedge wclk);
      while (!s_ready && t < 500) begin
         t++;
         @(negedge wclk);
      end
      if (!s_ready) begin
         chk("send_timeout", t, 0);
         @(posedge wclk);
         #1;
         s_valid = 1'b0;
         return;
      end
      @(posedge wclk);
      #1;
      s_valid = 1'b0;
      n_issued++;
   endtask

   // Wait (bounded) for the grant; keys must never be accepted meanwhile.
   task automatic wait_gnt(output int n);
      n = 0;
      do begin
         @(negedge wclk);
         n++;
         chk("s_ready_while_upd", 32'(s_ready), 32'd0);
      end while (!upd_gnt && n < 50);
      chk("gnt_reached", 32'(upd_gnt), 32'd1);
   endtask

   // Rewrite one rule through the ownership handshake.
   task automatic do_update(input int r, input logic [19:0] v, input logic [19:0] m, input logic e);
      int n;
      upd_req = 1'b1;
      wait_gnt(n);
      val[r] = v;
      msk[r] = m;
      en[r]  = e;
      upd_req = 1'b0;
      @(negedge wclk);
      chk("gnt_release", 32'(upd_gnt), 32'd0);
      @(posedge wclk);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_match", 32'(m_match), 32'd0);
      chk("rst_m_index", 32'(m_index), 32'd0);
      chk("rst_m_vec", 32'(m_vec), 32'd0);
      chk("rst_upd_gnt", 32'(upd_gnt), 32'd0);
      chk("rst_srl_addr", 32'(srl_addr), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int r = 0; r < 8; r++) begin
         val[r] = 20'h0;
         msk[r] = 20'h0;
      end

      // Reset state and first ready.
      repeat (2) @(posedge wclk);
      #1;
      check_reset_outputs();
      rst = 1'b0;
      #1;
      chk("s_ready_at_release", 32'(s_ready), 32'd0);
      @(posedge wclk);
      @(negedge wclk);
      chk("s_ready_after_release", 32'(s_ready), 32'd1);
      @(posedge wclk);
      #1;

      // Single lookup, latency check.
      do_update(3, 20'h12345, 20'hFFFFF, 1'b1);
      send(20'h12345);
      repeat (4) @(posedge wclk);
      #1;

      // Multiple matches and a miss.
      do_update(2, 20'h0AB00, 20'hFFF00, 1'b1);
      do_update(5, 20'h0AB0C, 20'hFFFFF, 1'b1);
      send(20'h0AB0C);
      send(20'hFFFFF);
      repeat (4) @(posedge wclk);
      #1;

      // More rules, then 8 back-to-back keys at full throughput.
      do_update(0, 20'h80000, 20'hF0000, 1'b1);
      do_update(7, 20'h00000, 20'h0000F, 1'b1);
      for (int i = 0; i < 8; i++) send(rand_key());
      repeat (4) @(posedge wclk);
      #1;

      // Back-pressure for 5 cycles mid-stream.
      lat_mode = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++) send(rand_key());
         end
         begin
            repeat (3) @(posedge wclk);
            #1;
            m_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge wclk);
               if (i > 0) chk("stall_s_ready", 32'(s_ready), 32'd0);
            end
            @(posedge wclk);
            #1;
            m_ready = 1'b1;
         end
      join
      repeat (5) @(posedge wclk);
      #1;

      // Update arbitration with two keys in flight.
      lat_mode = 1'b1;
      send(20'h12345);
      send(20'h0AB0C);
      upd_req = 1'b1;
      wait_gnt(n);
      chk("grant_latency", n, 4);
      chk("grant_after_drain", 32'(sbq.size()), 32'd0);
      val[3] = 20'h55555;
      upd_req = 1'b0;
      @(negedge wclk);
      chk("gnt_release_arb", 32'(upd_gnt), 32'd0);
      @(posedge wclk);
      #1;
      send(20'h55555);
      send(20'h12345);
      repeat (4) @(posedge wclk);
      #1;

      // upd_req and s_valid rise together: the update wins.
      s_key   = 20'h0AB0C;
      s_valid = 1'b1;
      upd_req = 1'b1;
      @(negedge wclk);
      chk("conflict_s_ready", 32'(s_ready), 32'd0);
      wait_gnt(n);
      upd_req = 1'b0;
      send(20'h0AB0C);
      repeat (4) @(posedge wclk);
      #1;

      // Short upd_req while draining a stalled pipe: no grant.
      lat_mode = 1'b0;
      m_ready  = 1'b0;
      send(rand_key());
      send(rand_key());
      upd_req = 1'b1;
      @(posedge wclk);
      #1;
      @(posedge wclk);
      #1;
      upd_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge wclk);
         chk("pulse_no_gnt", 32'(upd_gnt), 32'd0);
      end
      @(posedge wclk);
      #1;
      m_ready = 1'b1;
      send(20'h55555);
      repeat (5) @(posedge wclk);
      #1;

      // Asynchronous reset mid-stream.
      send(rand_key());
      send(rand_key());
      send(rand_key());
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs();
      sbq.delete();
      repeat (2) @(posedge wclk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge wclk);
         chk("no_stale_valid", 32'(m_valid), 32'd0);
      end
      @(posedge wclk);
      #1;

      // Randomised traffic with random back-pressure.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge wclk);
                  #1;
               end
               send(rand_key());
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge wclk);
               #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join

      n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(negedge wclk);
         n++;
      end
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      chk("accept_count", n_sent, n_issued);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
